// File: rtl/de_scoreboard.sv
// Decode-stage register hazard scoreboard with a saturating pending-write counter per register,
// multiple release ports and an optional same-cycle writeback bypass.
module de_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REGNOBITS = 5,
  parameter int CNT_W     = 2,
  parameter int NUM_REL   = 2,
  parameter int BYPASS_WB = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic                           dec_use_rs1,
  input  logic [REGNOBITS-1:0]           dec_rs1,
  input  logic                           dec_use_rs2,
  input  logic [REGNOBITS-1:0]           dec_rs2,
  input  logic                           dec_wr_reg,
  input  logic [REGNOBITS-1:0]           dec_rd,
  input  logic                           ext_stall,
  input  logic [NUM_REL-1:0]             rel_valid,
  input  logic [NUM_REL*REGNOBITS-1:0]   rel_regno,
  output logic                           dec_stall,
  output logic                           dec_alloc,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic                           err_underflow
);

  localparam int REL_W = $clog2(NUM_REL + 1);
  localparam int SUM_W = CNT_W + REL_W + 1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NUM_REGS-1:0] WRITABLE = {{(NUM_REGS-1){1'b1}}, 1'b0};

  // Indices at or beyond NUM_REGS select nothing, so they read as not busy / not writable.
  function automatic logic sel_bit(input logic [NUM_REGS-1:0] vec, input logic [REGNOBITS-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      hit = (idx == REGNOBITS'(r)) ? vec[r] : hit;
    end
    return hit;
  endfunction

  logic [CNT_W-1:0]    cnt_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic                err_r;

  logic [REL_W-1:0]    rel_cnt_s [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt_s [NUM_REGS];
  logic [NUM_REGS-1:0] eff_busy_s;
  logic [NUM_REGS-1:0] full_s;
  logic [NUM_REGS-1:0] uflow_s;
  logic [SUM_W-1:0]    sum_s;
  logic                rd_ok_s;
  logic                haz_s;
  logic                sat_s;

  // Count how many release ports target each register; register 0 never collects releases.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      rel_cnt_s[r] = {REL_W{1'b0}};
      for (int i = 0; i < NUM_REL; i++) begin
        rel_cnt_s[r] = rel_cnt_s[r] + REL_W'(rel_valid[i] && (r != 0) &&
                       (rel_regno[i*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)));
      end
    end
  end

  // Read-side busy view (optionally net of this cycle's releases) and saturation flags.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      full_s[r] = (cnt_r[r] == CNT_MAX);
      if (BYPASS_WB != 0) begin
        eff_busy_s[r] = SUM_W'(cnt_r[r]) > SUM_W'(rel_cnt_s[r]);
      end else begin
        eff_busy_s[r] = (cnt_r[r] != {CNT_W{1'b0}});
      end
    end
  end

  assign rd_ok_s   = dec_wr_reg && sel_bit(WRITABLE, dec_rd);
  assign haz_s     = (dec_use_rs1 && sel_bit(eff_busy_s, dec_rs1)) ||
                     (dec_use_rs2 && sel_bit(eff_busy_s, dec_rs2));
  assign sat_s     = rd_ok_s && sel_bit(full_s, dec_rd);
  assign dec_stall = dec_valid && (haz_s || sat_s || ext_stall);
  assign dec_alloc = dec_valid && rd_ok_s && !dec_stall;

  // Next count: add the accepted allocation, subtract releases, clamp to zero on underflow.
  always_comb begin
    sum_s = {SUM_W{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      sum_s = SUM_W'(cnt_r[r]) + SUM_W'(dec_alloc && (dec_rd == REGNOBITS'(r)));
      if (SUM_W'(rel_cnt_s[r]) > sum_s) begin
        cnt_nxt_s[r] = {CNT_W{1'b0}};
        uflow_s[r]   = 1'b1;
      end else begin
        cnt_nxt_s[r] = CNT_W'(sum_s - SUM_W'(rel_cnt_s[r]));
        uflow_s[r]   = 1'b0;
      end
    end
  end

  // Counter, busy flag and sticky underflow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= {CNT_W{1'b0}};
      end
      busy_r <= {NUM_REGS{1'b0}};
      err_r  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r]  <= cnt_nxt_s[r];
        busy_r[r] <= (cnt_nxt_s[r] != {CNT_W{1'b0}});
      end
      err_r <= err_r | (|uflow_s);
    end
  end

  assign busy_vec      = busy_r;
  assign err_underflow = err_r;

endmodule

// File: tb/tb_de_scoreboard.sv
// Self-checking bench for de_scoreboard: directed scenarios followed by random traffic,
// all compared against a count-per-register reference model.
module tb_de_scoreboard;

  localparam int BYP = 1;
  localparam int MAXC = 3;

  logic        clk, reset;
  logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_reg, ext_stall;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [1:0]  rel_valid;
  logic [9:0]  rel_regno;
  logic        dec_stall, dec_alloc, err_underflow;
  logic [31:0] busy_vec;

  de_scoreboard #(.NUM_REGS(32), .REGNOBITS(5), .CNT_W(2), .NUM_REL(2), .BYPASS_WB(BYP)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_use_rs1(dec_use_rs1), .dec_rs1(dec_rs1),
    .dec_use_rs2(dec_use_rs2), .dec_rs2(dec_rs2), .dec_wr_reg(dec_wr_reg), .dec_rd(dec_rd),
    .ext_stall(ext_stall), .rel_valid(rel_valid), .rel_regno(rel_regno), .dec_stall(dec_stall),
    .dec_alloc(dec_alloc), .busy_vec(busy_vec), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  bit         s_reset, s_valid, s_use1, s_use2, s_wr, s_ext;
  logic [4:0] s_rs1, s_rs2, s_rd, s_rr0, s_rr1;
  logic [1:0] s_rv;
  logic        o_stall, o_alloc, o_err;
  logic [31:0] o_busy;

  int mcnt [32];
  bit merr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    s_reset = 1'b0; s_valid = 1'b0; s_use1 = 1'b0; s_use2 = 1'b0; s_wr = 1'b0; s_ext = 1'b0;
    s_rs1 = 5'd0; s_rs2 = 5'd0; s_rd = 5'd0; s_rr0 = 5'd0; s_rr1 = 5'd0; s_rv = 2'b00;
  endtask

  function automatic int eff_of(input int c, input int rc);
    if (BYP != 0) return (c > rc) ? c - rc : 0;
    return c;
  endfunction

  // One clock: drive stimulus, compare outputs against the model, then advance the model.
  task automatic step(input string tag);
    int rc [32];
    bit haz, sat, est, eal;
    logic [31:0] ebusy;
    int v;
    @(negedge clk);
    reset = s_reset; dec_valid = s_valid; dec_use_rs1 = s_use1; dec_rs1 = s_rs1;
    dec_use_rs2 = s_use2; dec_rs2 = s_rs2; dec_wr_reg = s_wr; dec_rd = s_rd;
    ext_stall = s_ext; rel_valid = s_rv; rel_regno = {s_rr1, s_rr0};
    #1;
    for (int r = 0; r < 32; r++) rc[r] = 0;
    if (s_rv[0] && s_rr0 != 5'd0) rc[s_rr0]++;
    if (s_rv[1] && s_rr1 != 5'd0) rc[s_rr1]++;
    haz = (s_use1 && eff_of(mcnt[s_rs1], rc[s_rs1]) != 0) || (s_use2 && eff_of(mcnt[s_rs2], rc[s_rs2]) != 0);
    sat = s_wr && s_rd != 5'd0 && mcnt[s_rd] == MAXC;
    est = s_valid && (haz || sat || s_ext);
    eal = s_valid && s_wr && s_rd != 5'd0 && !est;
    for (int r = 0; r < 32; r++) ebusy[r] = (mcnt[r] != 0);
    o_stall = dec_stall; o_alloc = dec_alloc; o_busy = busy_vec; o_err = err_underflow;
    check({tag, ".stall"}, {31'd0, o_stall}, {31'd0, est});
    check({tag, ".alloc"}, {31'd0, o_alloc}, {31'd0, eal});
    check({tag, ".busy"}, o_busy, ebusy);
    check({tag, ".err"}, {31'd0, o_err}, {31'd0, merr});
    @(posedge clk);
    if (s_reset) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      merr = 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        v = mcnt[r] + ((eal && s_rd == 5'(r)) ? 1 : 0) - rc[r];
        if (v < 0) begin v = 0; merr = 1'b1; end
        mcnt[r] = v;
      end
    end
  endtask

  task automatic alloc(input logic [4:0] rd, input string tag);
    clr(); s_valid = 1'b1; s_wr = 1'b1; s_rd = rd; step(tag);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; dec_valid = 1'b0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    dec_wr_reg = 1'b0; ext_stall = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    rel_valid = 2'b00; rel_regno = 10'd0;
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
    repeat (2) @(posedge clk);

    clr(); s_reset = 1'b1; s_valid = 1'b1; s_ext = 1'b1; step("rst");
    check("rst_stall", {31'd0, o_stall}, 32'd1);
    check("rst_busy", o_busy, 32'd0);

    // Alloc then read-after-write, released in the fourth cycle.
    alloc(5'd5, "p1_alloc");
    check("p1_alloc_ok", {31'd0, o_alloc}, 32'd1);
    clr(); s_valid = 1'b1; s_use1 = 1'b1; s_rs1 = 5'd5;
    for (int k = 0; k < 3; k++) begin
      step("p1_read");
      check("p1_read_stall", {31'd0, o_stall}, 32'd1);
    end
    s_rv = 2'b01; s_rr0 = 5'd5; step("p1_rel");
    check("p1_bypass", {31'd0, o_stall}, 32'd0);

    // WAW: two pending writes need two releases.
    alloc(5'd5, "p2_a0"); alloc(5'd5, "p2_a1");
    clr(); s_rv = 2'b01; s_rr0 = 5'd5; step("p2_rel0");
    clr(); step("p2_idle0");
    check("p2_busy_after1", {31'd0, o_busy[5]}, 32'd1);
    clr(); s_rv = 2'b10; s_rr1 = 5'd5; step("p2_rel1");
    clr(); step("p2_idle1");
    check("p2_busy_after2", {31'd0, o_busy[5]}, 32'd0);

    // Saturation at three pending writes.
    for (int k = 0; k < 3; k++) alloc(5'd7, "p3_fill");
    alloc(5'd7, "p3_sat");
    check("p3_sat_stall", {31'd0, o_stall}, 32'd1);
    check("p3_sat_alloc", {31'd0, o_alloc}, 32'd0);
    clr(); s_valid = 1'b1; s_wr = 1'b1; s_rd = 5'd7; s_rv = 2'b01; s_rr0 = 5'd7; step("p3_relreq");
    check("p3_relreq_alloc", {31'd0, o_alloc}, 32'd0);
    alloc(5'd7, "p3_retry");
    check("p3_retry_alloc", {31'd0, o_alloc}, 32'd1);

    // Same-cycle alloc and release, then a double release.
    alloc(5'd3, "p4_a");
    clr(); s_valid = 1'b1; s_wr = 1'b1; s_rd = 5'd3; s_rv = 2'b01; s_rr0 = 5'd3; step("p4_both");
    check("p4_both_alloc", {31'd0, o_alloc}, 32'd1);
    clr(); step("p4_idle");
    check("p4_busy", {31'd0, o_busy[3]}, 32'd1);
    check("p4_err", {31'd0, o_err}, 32'd0);
    alloc(5'd3, "p5_a");
    clr(); s_rv = 2'b11; s_rr0 = 5'd3; s_rr1 = 5'd3; step("p5_rel2");
    clr(); step("p5_idle");
    check("p5_busy", {31'd0, o_busy[3]}, 32'd0);
    check("p5_err", {31'd0, o_err}, 32'd0);

    // Underflow, x0 handling and reset.
    clr(); s_rv = 2'b10; s_rr1 = 5'd9; step("p6_uflow");
    clr(); step("p6_idle");
    check("p6_err_set", {31'd0, o_err}, 32'd1);
    check("p6_busy9", {31'd0, o_busy[9]}, 32'd0);
    alloc(5'd0, "p6_x0");
    check("p6_x0_alloc", {31'd0, o_alloc}, 32'd0);
    clr(); step("p6_idle2");
    check("p6_x0_busy", {31'd0, o_busy[0]}, 32'd0);
    check("p6_err_sticky", {31'd0, o_err}, 32'd1);
    alloc(5'd5, "p6_a0"); alloc(5'd5, "p6_a1");
    clr(); s_reset = 1'b1; s_valid = 1'b1; s_wr = 1'b1; s_rd = 5'd6; s_rv = 2'b01; s_rr0 = 5'd9; step("p6_rst");
    clr(); step("p6_after_rst");
    check("p6_rst_busy", o_busy, 32'd0);
    check("p6_rst_err", {31'd0, o_err}, 32'd0);

    // Random traffic on a few registers so hazards and saturation occur often.
    for (int n = 0; n < 3000; n++) begin
      clr();
      s_reset = ($urandom_range(0, 149) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_use1 = 1'($urandom_range(0, 1)); s_rs1 = 5'($urandom_range(0, 7));
      s_use2 = 1'($urandom_range(0, 1)); s_rs2 = 5'($urandom_range(0, 7));
      s_wr = ($urandom_range(0, 3) != 0); s_rd = 5'($urandom_range(0, 7));
      s_ext = ($urandom_range(0, 7) == 0);
      s_rr0 = 5'($urandom_range(0, 7)); s_rr1 = 5'($urandom_range(0, 7));
      s_rv[0] = ($urandom_range(0, 2) == 0) && (mcnt[s_rr0] != 0 || $urandom_range(0, 19) == 0);
      s_rv[1] = ($urandom_range(0, 2) == 0) && (mcnt[s_rr1] != 0 || $urandom_range(0, 19) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
